pulse_measure: RTL

PULSE_MEASURE -- requirements
Module: pulse_measure

---
 rtl/pulse_measure_pkg.sv | 15 +
 rtl/pulse_measure_edge_sync.sv | 33 +++
 rtl/pulse_measure.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pulse_measure_pkg.sv
// Shared definitions for the pulse width / period measurement block.
package pulse_measure_pkg;

    // Default width of the cycle counters and measurement outputs.
    localparam int CNT_W_DEFAULT = 32;

    // Measurement FSM: IDLE waits for a first rising edge, HIGH counts the
    // high phase, LOW counts the remainder of the period.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_measure_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a third
// register so that rising/falling edges can be detected cleanly.
module edge_sync (
    input  logic I_CLK,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic level
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer stages plus the delayed copy used for edge detection.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;
    assign level = sync_q;

endmodule

// File: rtl/pulse_measure.sv
// Measures period (rise to rise) and high time (rise to fall) of sig_in in
// I_CLK cycles. A measurement is abandoned with a timeout pulse when the
// expected edge does not arrive within MAX_CNT cycles.
//
// meas_valid / timeout: single-cycle registered pulses, never together.
// period_out / high_out change only in the cycle meas_valid is high.
module pulse_measure
    import pulse_measure_pkg::*;
#(
    parameter int                 CNT_W   = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0]   MAX_CNT = {CNT_W{1'b1}}
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic rise_det;
    logic fall_det;
    logic sig_level_unused;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] high_cap_q, high_cap_d;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] high_d;
    logic             meas_valid_d;
    logic             timeout_d;

    edge_sync u_edge_sync (
        .I_CLK (I_CLK),
        .rst   (rst),
        .d     (sig_in),
        .rise  (rise_det),
        .fall  (fall_det),
        .level (sig_level_unused)
    );

    // State, counter and output registers.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_cap_q <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
            period_out <= period_d;
            high_out   <= high_d;
            meas_valid <= meas_valid_d;
            timeout    <= timeout_d;
        end
    end

    // Next-state and next-value logic; the timeout check outranks the
    // increment so cnt saturates at MAX_CNT instead of wrapping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        high_cap_d   = high_cap_q;
        period_d     = period_out;
        high_d       = high_out;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_det) begin
                    cnt_d   = ONE;
                    state_d = HIGH;
                end else begin
                    cnt_d = '0;
                end
            end

            HIGH: begin
                // A rise here cannot happen (a fall must come first); ignore it.
                if (fall_det) begin
                    high_cap_d = cnt_q;
                    cnt_d      = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + ONE;
                    state_d    = LOW;
                end else if (cnt_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            LOW: begin
                if (rise_det) begin
                    period_d     = cnt_q;
                    high_d       = high_cap_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = ONE;
                    state_d      = HIGH;
                end else if (cnt_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
